// File: rtl/linebuf_3row_ctrl.sv
// Sequencer for the two cascaded line FIFOs feeding the 3x3 window stage.
// Row 0 fills FIFO1, row 1 shifts FIFO1 into FIFO2, and later rows emit
// vertically aligned 3-pixel columns. Both FIFOs are drained after the last row.
module linebuf_3row_ctrl #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_IMG_WIDTH  = 640,
  parameter int P_IMG_HEIGHT = 512
) (
  input  logic                                                    i_clk,
  input  logic                                                    i_rst,
  input  logic                                                    i_sof,
  input  logic                                                    i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0]                                 i_pix_data,
  output logic                                                    o_ready,
  output logic                                                    o_wr_en1,
  output logic [P_DATA_WIDTH-1:0]                                 o_din1,
  output logic                                                    o_rd_en1,
  input  logic [P_DATA_WIDTH-1:0]                                 i_dout1,
  input  logic                                                    i_full1,
  input  logic                                                    i_empty1,
  output logic                                                    o_wr_en2,
  output logic [P_DATA_WIDTH-1:0]                                 o_din2,
  output logic                                                    o_rd_en2,
  input  logic [P_DATA_WIDTH-1:0]                                 i_dout2,
  input  logic                                                    i_full2,
  input  logic                                                    i_empty2,
  output logic                                                    o_col_valid,
  output logic [P_DATA_WIDTH-1:0]                                 o_col_top,
  output logic [P_DATA_WIDTH-1:0]                                 o_col_mid,
  output logic [P_DATA_WIDTH-1:0]                                 o_col_bot,
  output logic [((P_IMG_WIDTH  > 1) ? $clog2(P_IMG_WIDTH)  : 1)-1:0] o_col_x,
  output logic [((P_IMG_HEIGHT > 1) ? $clog2(P_IMG_HEIGHT) : 1)-1:0] o_col_y,
  output logic                                                    o_busy,
  output logic                                                    o_err
);

  localparam int XW = (P_IMG_WIDTH  > 1) ? $clog2(P_IMG_WIDTH)  : 1;
  localparam int YW = (P_IMG_HEIGHT > 1) ? $clog2(P_IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(P_IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(P_IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW0,
    S_ROW1,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t state, state_n;

  logic [XW-1:0]           x_cnt;
  logic [YW-1:0]           y_cnt;
  logic                    accept;
  logic                    sof_take;
  logic                    err_set;
  logic                    wr2_q;
  logic                    col_valid_q;
  logic [P_DATA_WIDTH-1:0] pix_q;
  logic [XW-1:0]           col_x_q;
  logic [YW-1:0]           col_y_q;
  logic                    err_q;

  assign accept   = o_ready & i_pix_valid;
  assign sof_take = (state == S_IDLE) & i_sof;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and same-cycle FIFO strobes
  always_comb begin
    state_n  = state;
    o_ready  = 1'b0;
    o_wr_en1 = 1'b0;
    o_rd_en1 = 1'b0;
    o_rd_en2 = 1'b0;
    o_busy   = 1'b1;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_sof) begin
          state_n = S_ROW0;
        end
      end
      S_ROW0: begin
        o_ready  = 1'b1;
        o_wr_en1 = i_pix_valid;
        if (i_pix_valid && (x_cnt == X_LAST)) begin
          state_n = S_ROW1;
        end
      end
      S_ROW1: begin
        o_ready  = 1'b1;
        o_wr_en1 = i_pix_valid;
        o_rd_en1 = i_pix_valid;
        if (i_pix_valid && (x_cnt == X_LAST)) begin
          state_n = S_STREAM;
        end
      end
      S_STREAM: begin
        o_ready  = 1'b1;
        o_wr_en1 = i_pix_valid;
        o_rd_en1 = i_pix_valid;
        o_rd_en2 = i_pix_valid;
        if (i_pix_valid && (x_cnt == X_LAST) && (y_cnt == Y_LAST)) begin
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_rd_en1 = 1'b1;
        o_rd_en2 = 1'b1;
        if (x_cnt == X_LAST) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign o_din1 = o_wr_en1 ? i_pix_data : '0;

  // Raster position; during DRAIN the x counter doubles as the drain cycle count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (sof_take) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept || (state == S_DRAIN)) begin
      if (x_cnt == X_LAST) begin
        x_cnt <= '0;
        if (state != S_DRAIN) begin
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  // One-cycle pipeline: FIFO read data lands the cycle after the accepted pixel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr2_q       <= 1'b0;
      col_valid_q <= 1'b0;
      pix_q       <= '0;
      col_x_q     <= '0;
      col_y_q     <= '0;
    end else begin
      wr2_q       <= accept && ((state == S_ROW1) || (state == S_STREAM));
      col_valid_q <= accept && (state == S_STREAM);
      if (accept) begin
        pix_q   <= i_pix_data;
        col_x_q <= x_cnt;
        col_y_q <= y_cnt;
      end
    end
  end

  assign o_wr_en2    = wr2_q;
  assign o_din2      = wr2_q ? i_dout1 : '0;
  assign o_col_valid = col_valid_q;
  assign o_col_top   = col_valid_q ? i_dout2 : '0;
  assign o_col_mid   = col_valid_q ? i_dout1 : '0;
  assign o_col_bot   = col_valid_q ? pix_q   : '0;
  assign o_col_x     = col_x_q;
  assign o_col_y     = col_y_q;

  assign err_set = (i_sof & (state != S_IDLE))
                 | (i_pix_valid & ~o_ready)
                 | (o_wr_en1 & i_full1)
                 | (o_wr_en2 & i_full2)
                 | (o_rd_en1 & i_empty1)
                 | (o_rd_en2 & i_empty2);

  // Sticky protocol error, cleared only by an accepted start of frame
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (sof_take) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

endmodule

// File: tb/tb_linebuf_3row_ctrl.sv
// Bench for linebuf_3row_ctrl: behavioural FIFOs, a pixel-count frame model
// and a per-cycle compare process, plus literal column expectations.
module tb_linebuf_3row_ctrl;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int DEPTH = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic pv  = 1'b0;
  logic [DW-1:0] pd = '0;
  logic force_full1 = 1'b0;

  logic          o_ready, o_wr_en1, o_rd_en1, o_wr_en2, o_rd_en2;
  logic          o_col_valid, o_busy, o_err;
  logic [DW-1:0] o_din1, o_din2, o_col_top, o_col_mid, o_col_bot;
  logic [1:0]    o_col_x, o_col_y;

  logic [DW-1:0] dout1 = '0;
  logic [DW-1:0] dout2 = '0;
  logic full1_f = 1'b0, empty1 = 1'b1, full2 = 1'b0, empty2 = 1'b1;
  logic full1_in;
  assign full1_in = full1_f | force_full1;

  always #5 clk = ~clk;

  linebuf_3row_ctrl #(.P_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H)) dut (
    .i_clk(clk), .i_rst(rst), .i_sof(sof), .i_pix_valid(pv), .i_pix_data(pd),
    .o_ready(o_ready), .o_wr_en1(o_wr_en1), .o_din1(o_din1), .o_rd_en1(o_rd_en1),
    .i_dout1(dout1), .i_full1(full1_in), .i_empty1(empty1),
    .o_wr_en2(o_wr_en2), .o_din2(o_din2), .o_rd_en2(o_rd_en2),
    .i_dout2(dout2), .i_full2(full2), .i_empty2(empty2),
    .o_col_valid(o_col_valid), .o_col_top(o_col_top), .o_col_mid(o_col_mid),
    .o_col_bot(o_col_bot), .o_col_x(o_col_x), .o_col_y(o_col_y),
    .o_busy(o_busy), .o_err(o_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Standard-mode FIFOs: read data appears the cycle after the read strobe
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q1.delete(); q2.delete();
      dout1 <= '0; dout2 <= '0;
    end else begin
      if (o_rd_en1 && q1.size() > 0) dout1 <= q1.pop_front();
      if (o_rd_en2 && q2.size() > 0) dout2 <= q2.pop_front();
      if (o_wr_en1 && q1.size() < DEPTH) q1.push_back(o_din1);
      if (o_wr_en2 && q2.size() < DEPTH) q2.push_back(o_din2);
    end
    full1_f <= (q1.size() >= DEPTH);
    empty1  <= (q1.size() == 0);
    full2   <= (q2.size() >= DEPTH);
    empty2  <= (q2.size() == 0);
  end

  // Frame model: phase 0 idle, 1 receiving pixels, 2 draining
  int  m_phase = 0, m_n = 0, m_drain = 0;
  bit  m_err = 0;
  bit  exp_cv = 0, exp_wr2 = 0;
  int  exp_top, exp_mid, exp_bot, exp_x, exp_y, exp_din2;
  int  img[W*H];
  int  ph;
  bit  m_acc, m_set;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; m_n = 0; m_drain = 0; m_err = 0; exp_cv = 0; exp_wr2 = 0;
    end else begin
      ph    = m_phase;
      m_acc = (ph == 1) && pv;
      m_set = 0;
      exp_cv  = 0;
      exp_wr2 = 0;
      if (sof && ph != 0) m_set = 1;
      if (pv && ph != 1) m_set = 1;
      if (m_acc && force_full1) m_set = 1;
      if (m_acc) begin
        img[m_n] = int'(pd);
        if (m_n >= W) begin
          exp_wr2  = 1;
          exp_din2 = img[m_n - W];
        end
        if (m_n >= 2*W) begin
          exp_cv  = 1;
          exp_top = img[m_n - 2*W];
          exp_mid = img[m_n - W];
          exp_bot = int'(pd);
          exp_x   = m_n % W;
          exp_y   = m_n / W;
        end
        m_n++;
        if (m_n == W*H) begin
          m_phase = 2;
          m_drain = W;
        end
      end
      if (ph == 2) begin
        m_drain--;
        if (m_drain == 0) m_phase = 0;
      end
      if (ph == 0 && sof) begin
        m_phase = 1; m_n = 0; m_err = 0;
      end else if (m_set) begin
        m_err = 1;
      end
    end
  end

  // Column bookkeeping for the literal expectations
  int col_cnt = 0;
  int f_top, f_mid, f_bot, f_x, f_y, l_top, l_mid, l_bot, l_x, l_y;
  bit c_acc;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      c_acc = (m_phase == 1) && pv;
      check("ready", 32'(o_ready), 32'(m_phase == 1));
      check("busy", 32'(o_busy), 32'(m_phase != 0));
      check("wr_en1", 32'(o_wr_en1), 32'(c_acc));
      check("rd_en1", 32'(o_rd_en1), 32'((c_acc && m_n >= W) || m_phase == 2));
      check("rd_en2", 32'(o_rd_en2), 32'((c_acc && m_n >= 2*W) || m_phase == 2));
      check("wr_en2", 32'(o_wr_en2), 32'(exp_wr2));
      check("col_valid", 32'(o_col_valid), 32'(exp_cv));
      check("err", 32'(o_err), 32'(m_err));
      if (c_acc) check("din1", 32'(o_din1), 32'(pd));
      if (exp_wr2) check("din2", 32'(o_din2), 32'(exp_din2));
      if (exp_cv) begin
        check("col_top", 32'(o_col_top), 32'(exp_top));
        check("col_mid", 32'(o_col_mid), 32'(exp_mid));
        check("col_bot", 32'(o_col_bot), 32'(exp_bot));
        check("col_x", 32'(o_col_x), 32'(exp_x));
        check("col_y", 32'(o_col_y), 32'(exp_y));
      end
      if (o_col_valid) begin
        col_cnt++;
        if (col_cnt == 1) begin
          f_top = int'(o_col_top); f_mid = int'(o_col_mid); f_bot = int'(o_col_bot);
          f_x = int'(o_col_x); f_y = int'(o_col_y);
        end
        l_top = int'(o_col_top); l_mid = int'(o_col_mid); l_bot = int'(o_col_bot);
        l_x = int'(o_col_x); l_y = int'(o_col_y);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps/data
  task automatic send_frame(input int mode, input int base, input int sof_at,
                            input int full_at, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (mode == 2) begin
        pv = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      pv = 1'b1;
      pd = (mode == 2) ? DW'($urandom) : DW'(base + i);
      sof = (i == sof_at);
      force_full1 = (i == full_at);
      tick();
      pv = 1'b0; sof = 1'b0; force_full1 = 1'b0;
      if (mode == 1) tick();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && o_busy; k++) tick();
    check("idle_reached", 32'(o_busy), 32'(0));
  endtask

  task automatic check_cols(input string tag, input int base);
    check({tag, "_count"}, 32'(col_cnt), 32'(8));
    check({tag, "_first_top"}, 32'(f_top), 32'(base + 0));
    check({tag, "_first_mid"}, 32'(f_mid), 32'(base + 4));
    check({tag, "_first_bot"}, 32'(f_bot), 32'(base + 8));
    check({tag, "_first_xy"}, 32'(f_x * 16 + f_y), 32'(0 * 16 + 2));
    check({tag, "_last_top"}, 32'(l_top), 32'(base + 7));
    check({tag, "_last_mid"}, 32'(l_mid), 32'(base + 11));
    check({tag, "_last_bot"}, 32'(l_bot), 32'(base + 15));
    check({tag, "_last_xy"}, 32'(l_x * 16 + l_y), 32'(3 * 16 + 3));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_ready", 32'(o_ready), 32'(0));
    check("rst_col_valid", 32'(o_col_valid), 32'(0));
    check("rst_err", 32'(o_err), 32'(0));
    check("rst_wr_en2", 32'(o_wr_en2), 32'(0));
    tick();

    // Sequential frame, back-to-back pixels
    col_cnt = 0;
    start_frame();
    send_frame(0, 0, -1, -1, W*H);
    wait_idle();
    check_cols("seq", 0);
    check("seq_err", 32'(o_err), 32'(0));
    check("seq_empty1", 32'(empty1), 32'(1));
    check("seq_empty2", 32'(empty2), 32'(1));

    // Same frame, valid low every other cycle
    col_cnt = 0;
    start_frame();
    send_frame(1, 0, -1, -1, W*H);
    wait_idle();
    check_cols("gap", 0);

    // Back-to-back frames, sof in the first idle cycle
    col_cnt = 0;
    start_frame();
    send_frame(0, 100, -1, -1, W*H);
    wait_idle();
    check_cols("b2b", 100);
    start_frame();
    send_frame(2, 0, -1, -1, W*H);
    wait_idle();
    check("b2b_err", 32'(o_err), 32'(0));

    // sof inside ROW1 sets the sticky error but the frame continues
    col_cnt = 0;
    start_frame();
    send_frame(0, 50, W + 1, -1, W*H);
    wait_idle();
    check_cols("sof_row1", 50);
    check("sof_row1_err", 32'(o_err), 32'(1));
    start_frame();
    check("sof_clear_err", 32'(o_err), 32'(0));
    send_frame(2, 0, -1, -1, W*H);
    wait_idle();

    // Write into a full FIFO1 during ROW0
    start_frame();
    send_frame(0, 20, -1, 1, 2);
    check("full1_err", 32'(o_err), 32'(1));
    send_frame(0, 22, -1, -1, W*H - 2);
    wait_idle();

    // Pixel offered during DRAIN is dropped and flagged
    start_frame();
    check("drain_pre_err", 32'(o_err), 32'(0));
    send_frame(0, 30, -1, -1, W*H);
    pv = 1'b1; pd = 8'hAA;
    #1;
    check("drain_no_wr1", 32'(o_wr_en1), 32'(0));
    tick();
    pv = 1'b0;
    check("drain_pix_err", 32'(o_err), 32'(1));
    wait_idle();
    check("drain_empty1", 32'(empty1), 32'(1));
    check("drain_empty2", 32'(empty2), 32'(1));

    // Asynchronous reset at STREAM x=2
    start_frame();
    send_frame(0, 60, -1, -1, 2*W + 2);
    pv = 1'b1; pd = 8'd70;
    #1 rst = 1'b1;
    #1;
    check("arst_wr_en1", 32'(o_wr_en1), 32'(0));
    check("arst_rd_en1", 32'(o_rd_en1), 32'(0));
    check("arst_rd_en2", 32'(o_rd_en2), 32'(0));
    check("arst_wr_en2", 32'(o_wr_en2), 32'(0));
    check("arst_col_valid", 32'(o_col_valid), 32'(0));
    check("arst_busy", 32'(o_busy), 32'(0));
    tick();
    pv = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    col_cnt = 0;
    start_frame();
    send_frame(0, 200, -1, -1, W*H);
    wait_idle();
    check_cols("post_rst", 200);
    check("post_rst_err", 32'(o_err), 32'(0));

    // Random frames with random gaps
    for (int f = 0; f < 4; f++) begin
      col_cnt = 0;
      start_frame();
      send_frame(2, 0, -1, -1, W*H);
      wait_idle();
      check("rand_count", 32'(col_cnt), 32'(8));
      check("rand_empty1", 32'(empty1), 32'(1));
      check("rand_empty2", 32'(empty2), 32'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/linebuf_3row_ctrl.md
Name: linebuf_3row_ctrl

Overview:
Sequencer for the dual line-buffer FIFO pair that feeds the 3x3 window stage of the infrared pipeline. It takes a raster pixel stream and writes each pixel into line FIFO 1. It cascades FIFO 1 output into FIFO 2 and emits vertically aligned 3-pixel columns (rows y-2, y-1, y) to the downstream window/filter. After the last row it drains both FIFOs, so every frame starts with both FIFOs empty.

Parameters:
P_DATA_WIDTH, 8, pixel width in bits
P_IMG_WIDTH, 640, pixels per row; line FIFO depth must be >= this
P_IMG_HEIGHT, 512, rows per frame (>= 3)

Ports:
i_clk  in  1  single clock for the controller and both FIFOs
i_rst  in  1  reset, asynchronous, active-high
i_sof  in  1  start-of-frame pulse, accepted only in IDLE
i_pix_valid  in  1  input pixel strobe; gaps allowed
i_pix_data  in  P_DATA_WIDTH  input pixel
o_ready  out  1  high in ROW0/ROW1/STREAM
o_wr_en1  out  1  FIFO1 write
o_din1  out  P_DATA_WIDTH  FIFO1 write data
o_rd_en1  out  1  FIFO1 read
i_dout1  in  P_DATA_WIDTH  FIFO1 read data, valid 1 cycle after o_rd_en1 (std mode)
i_full1, i_empty1  in  1 each  FIFO1 flags
o_wr_en2  out  1  FIFO2 write
o_din2  out  P_DATA_WIDTH  FIFO2 write data
o_rd_en2  out  1  FIFO2 read
i_dout2  in  P_DATA_WIDTH  FIFO2 read data, 1-cycle latency
i_full2, i_empty2  in  1 each  FIFO2 flags
o_col_valid  out  1  column output strobe
o_col_top / o_col_mid / o_col_bot  out  P_DATA_WIDTH each  rows y-2 / y-1 / y
o_col_x  out  clog2(P_IMG_WIDTH)  column index of output
o_col_y  out  clog2(P_IMG_HEIGHT)  row index of o_col_bot
o_busy  out  1  high in any state except IDLE
o_err  out  1  sticky protocol/flag error

Behaviour:
- Reset: state IDLE; all outputs 0; x/y counters 0; o_err 0.
- Counters:
  - x advances on each accepted pixel (o_ready & i_pix_valid).
  - When x reaches P_IMG_WIDTH-1, x wraps to 0 and y increments.
- States:
  - IDLE: i_sof moves to ROW0 and clears o_err. A same-cycle pixel is not accepted.
  - ROW0 (y=0): each accepted pixel: o_wr_en1=1, o_din1=pixel, same cycle. No reads. Go to ROW1 at end of row.
  - ROW1 (y=1): each accepted pixel: o_rd_en1=1 and o_wr_en1=1 in the same cycle. The pixel is registered. On the next cycle: o_wr_en2=1, o_din2=i_dout1. No column output. Go to STREAM at end of row.
  - STREAM (y=2..H-1): each accepted pixel: o_rd_en1=o_rd_en2=o_wr_en1=1. Pixel, x and y are registered. On the next cycle:
    - o_wr_en2=1, o_din2=i_dout1
    - o_col_valid=1, top=i_dout2, mid=i_dout1, bot=registered pixel
    - Fixed latency: 1 cycle from accepted pixel to column.
    - After the last pixel of row H-1, go to DRAIN.
  - DRAIN: P_IMG_WIDTH consecutive cycles of o_rd_en1=o_rd_en2=1; read data is discarded and no writes occur. Then go to IDLE. The FIFOs must now report empty1=empty2=1.
- Back-to-back pixels every cycle must be sustained in all data states. FIFO1 may be written and read in the same cycle.
- o_err is set, and stays set until the next accepted i_sof or reset, on any of:
  - i_sof outside IDLE; the pulse is otherwise ignored.
  - i_pix_valid while o_ready=0; the pixel is dropped.
  - Any write issued while the corresponding full flag is 1.
  - Any read issued while the corresponding empty flag is 1.
- Flag checks never gate the datapath; the sequence proceeds regardless.
- Reset mid-frame: immediate return to IDLE with all strobes 0. FIFO content is not guaranteed; the integrator resets the FIFOs with the same reset.

Test Plan:
- W=4,H=4, frame pixels 0..15 back-to-back after i_sof:
  - exactly 8 o_col_valid pulses;
  - first column (x=0,y=2) = top 0, mid 4, bot 8;
  - last column (x=3,y=3) = top 7, mid 11, bot 15;
  - o_err=0; after DRAIN (4 cycles), empty1=empty2=1 and o_busy=0.
- Same frame with i_pix_valid low every other cycle: identical column values and x/y, each column exactly 1 cycle after its bottom pixel.
- Two frames back-to-back (second i_sof in the cycle after return to IDLE): second-frame columns contain only second-frame data, and o_err=0.
- i_sof pulsed during ROW1: o_err=1, frame continues unaffected, columns still correct. The next valid i_sof clears o_err.
- Force i_full1=1 during a ROW0 write: o_err=1 in the following cycle. Pixel applied in DRAIN: o_err=1 and no FIFO write.
- Assert i_rst during STREAM at x=2: all strobes 0 and o_busy=0 in the same cycle. After release, a new i_sof gives a correct full frame.
